// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier, 32 iterations per op.
// Produces the 64-bit Product for the Hi/Lo stage. Signed operands are converted
// to magnitudes, multiplied unsigned, and the sign is restored at the end.
// Optional macro EARLY_TERM_EN: a zero operand skips straight to FINISH.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Busy,
    output logic                 Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    // {carry, partial-product upper half, remaining multiplier bits}
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     step;

    // Next-state logic: operand capture, one add/shift per RUN cycle, sign fix-up in FINISH
    always_comb begin
        mag_a   = (Signed && A[WIDTH-1]) ? -A : A;
        mag_b   = (Signed && B[WIDTH-1]) ? -B : B;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        step    = acc_q;
        if (acc_q[0]) begin
            step[2*WIDTH:WIDTH] = sum;
        end

        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mcand_d = mag_a;
                    acc_d   = {{(WIDTH+1){1'b0}}, mag_b};
                    neg_d   = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
`ifdef EARLY_TERM_EN
                    // Clearing the accumulator and sign makes FINISH emit exactly 0.
                    if (A == '0 || B == '0) begin
                        acc_d   = '0;
                        neg_d   = 1'b0;
                        state_d = S_FINISH;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d = step >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                prod_d  = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Product = prod_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected results,
// a negedge monitor pops them on Done and checks product, latency, Busy and hold.
module tb_seq_multiplier;

    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Signed;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [2*W-1:0] Product;
    logic          Busy;
    logic          Done;

    seq_multiplier #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Signed  (Signed),
        .A       (A),
        .B       (B),
        .Product (Product),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int unsigned sample;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] hold_exp = '0;
    logic        done_prev = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: full-width arithmetic product of the operands as integers
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            return 64'(pa * pb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int unsigned lat(input logic [31:0] a, input logic [31:0] b);
`ifdef EARLY_TERM_EN
        if (a == 0 || b == 0) return 1;
`endif
        return 33;
    endfunction

    // Monitor: checks results on Done, and Busy/Product stability otherwise
    always @(negedge Clk) begin
        exp_t e;
        logic bexp;
        if (Reset) begin
            hold_exp <= '0;
        end else if (Done) begin
            chk("done_one_cycle", {63'b0, done_prev}, 64'd0);
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_done: got Done=1, want no result pending (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("product", Product, e.prod);
                chk("latency", 64'(cyc), 64'(e.due));
                hold_exp <= e.prod;
            end
        end else begin
            chk("product_hold", Product, hold_exp);
            bexp = 1'b0;
            if (sb.size() != 0) begin
                if (cyc >= sb[0].sample) bexp = 1'b1;
            end
            chk("busy", {63'b0, Busy}, {63'b0, bexp});
        end
        done_prev <= Done & ~Reset;
    end

    // Drive one Start pulse at a negedge; accepted requests go to the scoreboard
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit accept);
        exp_t e;
        Start  = 1'b1;
        A      = a;
        B      = b;
        Signed = s;
        if (accept) begin
            e.prod   = model(a, b, s);
            e.sample = cyc + 1;
            e.due    = e.sample + lat(a, b);
            sb.push_back(e);
        end
        @(negedge Clk);
        Start  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        Signed = 1'($urandom_range(0, 1));
    endtask

    // Bounded wait; returns at the negedge where Done is seen
    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout_%s: got no Done, want Done within 60 cycles", tag);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] want;
    } vec_t;

    vec_t dirs[5] = '{
        '{32'd7,         32'd6,         1'b0, 64'h000000000000002A},
        '{32'hFFFFFFFD,  32'd5,         1'b1, 64'hFFFFFFFFFFFFFFF1},
        '{32'hFFFFFFFD,  32'd5,         1'b0, 64'h00000004FFFFFFF1},
        '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFFFFFE00000001},
        '{32'h80000000,  32'h80000000,  1'b1, 64'h4000000000000000}
    };

    logic [31:0] corners[5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

    initial begin
        logic [31:0] ra, rb;
        Reset  = 1'b1;
        Start  = 1'b0;
        Signed = 1'b0;
        A      = '0;
        B      = '0;
        repeat (3) @(negedge Clk);
        chk("reset_product", Product, 64'd0);
        chk("reset_busy", {63'b0, Busy}, 64'd0);
        chk("reset_done", {63'b0, Done}, 64'd0);
        #2 Reset = 1'b0;
        @(negedge Clk);

        foreach (dirs[i]) begin
            issue(dirs[i].a, dirs[i].b, dirs[i].s, 1'b1);
            wait_done("directed");
            chk("directed_const", Product, dirs[i].want);
            @(negedge Clk);
        end

        // Start while busy is ignored
        issue(32'd3, 32'd4, 1'b0, 1'b1);
        repeat (9) @(negedge Clk);
        issue(32'd9, 32'd9, 1'b0, 1'b0);
        wait_done("busy_ignore");
        chk("busy_ignore_const", Product, 64'd12);
        @(negedge Clk);

        // Asynchronous reset mid-operation
        issue(32'd2, 32'd2, 1'b0, 1'b1);
        repeat (14) @(negedge Clk);
        #2 Reset = 1'b1;
        sb.delete();
        #1;
        chk("abort_busy", {63'b0, Busy}, 64'd0);
        chk("abort_done", {63'b0, Done}, 64'd0);
        chk("abort_product", Product, 64'd0);
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b0;
        @(negedge Clk);
        issue(32'd5, 32'd5, 1'b0, 1'b1);
        wait_done("after_reset");
        chk("after_reset_const", Product, 64'd25);

        // Back-to-back: Start during the Done cycle
        @(negedge Clk);
        issue(32'd11, 32'd13, 1'b0, 1'b1);
        wait_done("b2b_first");
        issue(32'd100, 32'd3, 1'b0, 1'b1);
        repeat (10) @(negedge Clk);
        chk("b2b_hold_const", Product, 64'd143);
        wait_done("b2b_second");
        chk("b2b_const", Product, 64'd300);
        @(negedge Clk);

        // Zero operands (early termination when enabled)
        issue(32'd0, 32'hDEADBEEF, 1'b1, 1'b1);
        wait_done("zero_a");
        chk("zero_a_const", Product, 64'd0);
        @(negedge Clk);
        issue(32'h12345678, 32'd0, 1'b0, 1'b1);
        wait_done("zero_b");
        chk("zero_b_const", Product, 64'd0);

        // Randomized operations, corners mixed in, some back-to-back
        for (int n = 0; n < 24; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            if ($urandom_range(0, 1) == 0) @(negedge Clk);
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            wait_done("random");
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
